// File: rtl/reset_release_sequencer.sv
`timescale 1ns/1ps
// reset_release_sequencer: releases NUM_OUTPUTS reset domains strictly in
// index order, STAGE_DELAY clocks apart, after a POR-driven async reset.
// Build option RESET_SEQ_ACK_EN: when defined, each release waits for
// stage_ack[idx] (bounded by ACK_TIMEOUT) and seq_error/error_stage are
// live; when undefined, acks are ignored and the error outputs stay 0.
// Ports:
//   clk          single clock for all logic
//   reset        async active-high reset from the power-on reset block
//   reset_req    sync level-high soft reset; re-asserts all domains
//   stage_ack    per-domain release acknowledge, synchronous to clk
//   reset_out    per-domain active-high reset, registered
//   seq_done     every domain released and acked (or timed out)
//   seq_error    sticky: at least one stage timed out
//   error_stage  index of the first stage that timed out
module reset_release_sequencer #(
    parameter int NUM_OUTPUTS = 4,
    parameter int STAGE_DELAY = 16,
    parameter int ACK_TIMEOUT = 255,
    localparam int IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reset_req,
    input  logic [NUM_OUTPUTS-1:0] stage_ack,
    output logic [NUM_OUTPUTS-1:0] reset_out,
    output logic                   seq_done,
    output logic                   seq_error,
    output logic [IDX_W-1:0]       error_stage
);

    localparam int CNT_TOP =
        (STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT;
    localparam int CNT_W = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_TOP);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUTPUTS - 1);
`ifdef RESET_SEQ_ACK_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
`endif

    localparam logic [1:0] S_HOLD     = 2'd0;
    localparam logic [1:0] S_DELAY    = 2'd1;
`ifdef RESET_SEQ_ACK_EN
    localparam logic [1:0] S_WAIT_ACK = 2'd2;
`endif
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic [NUM_OUTPUTS-1:0] rst_out_q, rst_out_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [IDX_W-1:0]       err_stg_q, err_stg_d;

    // Release request for this edge and the stage it applies to.
    logic                   rel;
    logic [IDX_W-1:0]       rel_idx;

`ifdef RESET_SEQ_ACK_EN
    logic ack_cur;
    assign ack_cur = stage_ack[idx_q];
`else
    logic ack_unused;
    assign ack_unused = ^stage_ack;
`endif

    // The counter never wraps; it parks at its terminal value.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
        err_d     = err_q;
        err_stg_d = err_stg_q;
        rel       = 1'b0;
        rel_idx   = idx_q;
        if (reset_req) begin
            // Soft reset overrides any release due on this edge.
            state_d   = S_HOLD;
            idx_d     = '0;
            cnt_d     = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
            err_d     = 1'b0;
            err_stg_d = '0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (cnt_q == DLY_LAST) begin
                        rel     = 1'b1;
                        rel_idx = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_DELAY: begin
                    if (cnt_q == DLY_LAST) begin
                        rel     = 1'b1;
                        rel_idx = idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`ifdef RESET_SEQ_ACK_EN
                S_WAIT_ACK: begin
                    if (ack_cur || (cnt_q == TMO_LAST)) begin
                        // A timeout advances exactly like an ack.
                        if (!ack_cur) begin
                            err_d = 1'b1;
                            if (!err_q) begin
                                err_stg_d = idx_q;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DELAY;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
            if (rel) begin
                rst_out_d[rel_idx] = 1'b0;
                idx_d              = rel_idx;
                cnt_d              = '0;
`ifdef RESET_SEQ_ACK_EN
                state_d            = S_WAIT_ACK;
`else
                if (rel_idx == IDX_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DELAY;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_HOLD;
            idx_q     <= '0;
            cnt_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_stg_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_stg_q <= err_stg_d;
        end
    end

    assign reset_out   = rst_out_q;
    assign seq_done    = done_q;
    assign seq_error   = err_q;
    assign error_stage = err_stg_q;

    // Released domains always form a contiguous run from bit 0.
    logic [NUM_OUTPUTS-1:0] rel_mask;
    logic [NUM_OUTPUTS-1:0] rel_mask_inc;
    assign rel_mask     = ~rst_out_q;
    assign rel_mask_inc = rel_mask + NUM_OUTPUTS'(1);

    a_order: assert property (@(posedge clk) disable iff (reset)
        (rel_mask & rel_mask_inc) == '0);

    a_done: assert property (@(posedge clk) disable iff (reset)
        done_q |-> (rst_out_q == '0));

endmodule
